// File: rtl/fbuff_pkg.sv
// Shared frame buffer types and default geometry, used by the arbiter, frame buffer and line controller.
package fbuff_pkg;

    localparam int FBUFF_ADDR_WIDTH = 12;
    localparam int FBUFF_WIDTH      = 60;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_RD_WAIT,
        ARB_WR
    } fbuff_arb_state_t;

endpackage

// File: rtl/fbuff_arbiter.sv
// Arbitrates the single-port frame buffer between line fetch reads and pixel writes.
// Grants are combinational in ARB_IDLE; a read takes 4 cycles from grant to rd_valid, a write occupies 2 cycles.
module fbuff_arbiter #(
    parameter int FBUFF_ADDR_WIDTH = fbuff_pkg::FBUFF_ADDR_WIDTH,
    parameter int FBUFF_WIDTH      = fbuff_pkg::FBUFF_WIDTH,
    parameter int MAX_RD_BURST     = 4,
    parameter int RSP_TIMEOUT      = 8
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        rd_req_i,
    input  logic [FBUFF_ADDR_WIDTH-1:0] rd_addr_i,
    output logic                        rd_gnt_o,
    output logic                        rd_valid_o,
    output logic [FBUFF_WIDTH-1:0]      rd_data_o,
    output logic                        rd_err_o,
    input  logic                        wr_req_i,
    input  logic [FBUFF_ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [FBUFF_WIDTH-1:0]      wr_data_i,
    output logic                        wr_gnt_o,
    output logic [FBUFF_ADDR_WIDTH-1:0] fb_addr_o,
    output logic [FBUFF_WIDTH-1:0]      fb_din_o,
    output logic                        fb_we_o,
    output logic                        fb_en_o,
    output logic                        fb_rd_req_o,
    input  logic                        fb_rd_rsp_i,
    input  logic [FBUFF_WIDTH-1:0]      fb_dout_i,
    output logic                        err_o
);

    import fbuff_pkg::*;

    localparam int SW = $clog2(MAX_RD_BURST + 1);
    localparam int TW = $clog2(RSP_TIMEOUT + 1);

    fbuff_arb_state_t state, state_nxt;
    logic [SW-1:0]    starve_cnt;
    logic [TW-1:0]    tmo_cnt;
    logic             rsp_hit;
    logic             tmo_hit;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_gnt_o  = 1'b0;
        wr_gnt_o  = 1'b0;
        rsp_hit   = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            ARB_IDLE: begin
                // A pending write only yields to reads until the burst allowance is used up.
                if (wr_req_i && ((starve_cnt == SW'(MAX_RD_BURST)) || !rd_req_i)) begin
                    wr_gnt_o  = 1'b1;
                    state_nxt = ARB_WR;
                end else if (rd_req_i) begin
                    rd_gnt_o  = 1'b1;
                    state_nxt = ARB_RD_WAIT;
                end
            end
            ARB_RD_WAIT: begin
                if (fb_rd_rsp_i) begin
                    rsp_hit   = 1'b1;
                    state_nxt = ARB_IDLE;
                end else if (tmo_cnt == TW'(RSP_TIMEOUT - 1)) begin
                    tmo_hit   = 1'b1;
                    state_nxt = ARB_IDLE;
                end
            end
            ARB_WR: begin
                state_nxt = ARB_IDLE;
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            fb_addr_o   <= '0;
            fb_din_o    <= '0;
            fb_we_o     <= 1'b0;
            fb_en_o     <= 1'b0;
            fb_rd_req_o <= 1'b0;
        end else begin
            fb_rd_req_o <= rd_gnt_o;
            fb_we_o     <= wr_gnt_o;
            if (rd_gnt_o) begin
                fb_addr_o <= rd_addr_i;
                fb_en_o   <= 1'b1;
            end else if (wr_gnt_o) begin
                fb_addr_o <= wr_addr_i;
                fb_din_o  <= wr_data_i;
                fb_en_o   <= 1'b1;
            end else if (state_nxt == ARB_IDLE) begin
                fb_en_o   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
            rd_err_o   <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            rd_valid_o <= rsp_hit;
            rd_err_o   <= tmo_hit;
            if (rsp_hit) begin
                rd_data_o <= fb_dout_i;
            end
            if (tmo_hit) begin
                err_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tmo_cnt <= '0;
        end else if ((state == ARB_RD_WAIT) && (state_nxt == ARB_RD_WAIT)) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    // Counts reads granted over a waiting write; any idle cycle without a write request forgets the history.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            starve_cnt <= '0;
        end else if (wr_gnt_o) begin
            starve_cnt <= '0;
        end else if (rd_gnt_o && wr_req_i) begin
            if (starve_cnt != SW'(MAX_RD_BURST)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end else if ((state == ARB_IDLE) && !wr_req_i) begin
            starve_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_fbuff_arbiter.sv
// Directed bench for fbuff_arbiter with a two-cycle frame buffer model downstream.
module tb_fbuff_arbiter;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b1;
    logic        rd_req_i = 1'b0;
    logic [11:0] rd_addr_i = '0;
    logic        rd_gnt_o;
    logic        rd_valid_o;
    logic [59:0] rd_data_o;
    logic        rd_err_o;
    logic        wr_req_i = 1'b0;
    logic [11:0] wr_addr_i = '0;
    logic [59:0] wr_data_i = '0;
    logic        wr_gnt_o;
    logic [11:0] fb_addr_o;
    logic [59:0] fb_din_o;
    logic        fb_we_o;
    logic        fb_en_o;
    logic        fb_rd_req_o;
    logic        fb_rd_rsp_i;
    logic [59:0] fb_dout_i;
    logic        err_o;

    int n_checks = 0;
    int n_errors = 0;
    int excl_viol = 0;
    logic no_rsp = 1'b0;

    always #5 clk_i = ~clk_i;

    fbuff_arbiter dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_gnt_o(rd_gnt_o),
        .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_err_o(rd_err_o),
        .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_gnt_o(wr_gnt_o),
        .fb_addr_o(fb_addr_o), .fb_din_o(fb_din_o), .fb_we_o(fb_we_o), .fb_en_o(fb_en_o),
        .fb_rd_req_o(fb_rd_req_o), .fb_rd_rsp_i(fb_rd_rsp_i), .fb_dout_i(fb_dout_i),
        .err_o(err_o)
    );

    function automatic logic [59:0] pattern(input logic [11:0] a);
        return {12'hA5C, ~a, 12'h3C3, a, a ^ 12'h5A5};
    endfunction

    // Frame buffer model: request seen one cycle, response pulse the next.
    logic [59:0] fb_mem [4096];
    bit   [4095:0] fb_seen;
    logic        fb_stg;
    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            fb_stg      <= 1'b0;
            fb_rd_rsp_i <= 1'b0;
            fb_dout_i   <= '0;
        end else begin
            fb_stg      <= fb_rd_req_o;
            fb_rd_rsp_i <= fb_stg && !no_rsp;
            if (fb_stg) fb_dout_i <= fb_seen[fb_addr_o] ? fb_mem[fb_addr_o] : pattern(fb_addr_o);
            if (fb_en_o && fb_we_o) begin
                fb_mem[fb_addr_o]  <= fb_din_o;
                fb_seen[fb_addr_o] <= 1'b1;
            end
        end
    end

    always @(negedge clk_i) if (fb_we_o && fb_rd_req_o) excl_viol++;

    logic [59:0] exp_mem [4096];
    bit   [4095:0] exp_seen;

    function automatic logic [59:0] exp_rd(input logic [11:0] a);
        return exp_seen[a] ? exp_mem[a] : pattern(a);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Entered and left at posedge+1; registered outputs sampled at +1, grants at +2.
    task automatic do_read(input logic [11:0] a, output logic [59:0] d, output int gw,
                           output int lat, output logic er, output logic [31:0] mask,
                           output logic [11:0] aseen);
        int n;
        d = '0; er = 1'b0; lat = -1; gw = -1; mask = '0; aseen = '0;
        rd_req_i = 1'b1;
        rd_addr_i = a;
        n = 0;
        forever begin
            #1;
            if (rd_gnt_o) break;
            if (n >= 50) break;
            @(posedge clk_i); #1;
            n++;
        end
        if (!rd_gnt_o) begin
            chk("rd_gnt_wait", 0, 1);
            rd_req_i = 1'b0;
            tick();
            return;
        end
        gw = n;
        tick();
        rd_req_i = 1'b0;
        n = 1;
        forever begin
            if (fb_rd_req_o) mask[n] = 1'b1;
            if (n == 1) aseen = fb_addr_o;
            if (rd_valid_o || rd_err_o) begin
                d = rd_data_o; er = rd_err_o; lat = n;
                return;
            end
            if (n >= 30) begin
                chk("rd_done_wait", 0, 1);
                return;
            end
            tick();
            n++;
        end
    endtask

    task automatic do_write(input logic [11:0] a, input logic [59:0] dat, output int gw,
                            output logic [3:0] fl, output logic [11:0] aseen,
                            output logic [59:0] dseen, output logic we_after);
        int n;
        gw = -1; fl = '0; aseen = '0; dseen = '0; we_after = 1'b0;
        wr_req_i = 1'b1; wr_addr_i = a; wr_data_i = dat;
        n = 0;
        forever begin
            #1;
            if (wr_gnt_o || n >= 50) break;
            @(posedge clk_i); #1;
            n++;
        end
        if (!wr_gnt_o) begin
            chk("wr_gnt_wait", 0, 1);
            wr_req_i = 1'b0;
            tick();
            return;
        end
        gw = n;
        exp_mem[a] = dat;
        exp_seen[a] = 1'b1;
        tick();
        wr_req_i = 1'b0;
        fl = {fb_we_o, fb_en_o, fb_rd_req_o, rd_gnt_o};
        aseen = fb_addr_o;
        dseen = fb_din_o;
        tick();
        we_after = fb_we_o;
    endtask

    logic [59:0] d, last_d;
    int gw, lat;
    logic er, wa;
    logic [31:0] mask;
    logic [11:0] as;
    logic [3:0] fl;
    logic [59:0] ds;

    initial begin
        #2 rstn_i = 1'b0;
        #1;
        chk("rst_fb_en", fb_en_o, 0);
        chk("rst_outs", {rd_valid_o, rd_err_o, err_o, fb_we_o, fb_rd_req_o}, 0);
        repeat (3) @(posedge clk_i);
        #1 rstn_i = 1'b1;
        tick();
        chk("rst_rd_data", rd_data_o, 0);
        chk("rst_fb_addr", fb_addr_o, 0);
        chk("rst_gnts", {rd_gnt_o, wr_gnt_o}, 0);

        // 1: nominal read
        do_read(12'h010, d, gw, lat, er, mask, as);
        chk("t1_gnt_wait", gw, 0);
        chk("t1_latency", lat, 4);
        chk("t1_fb_rd_req_mask", mask, 32'h2);
        chk("t1_fb_addr", as, 12'h010);
        chk("t1_data", d, pattern(12'h010));
        chk("t1_err", er, 0);
        tick();
        chk("t1_valid_pulse", rd_valid_o, 0);
        chk("t1_data_hold", rd_data_o, pattern(12'h010));
        chk("t1_fb_en_idle", fb_en_o, 0);

        // 2: write then read back; second write back-to-back
        do_write(12'h123, 60'hABC, gw, fl, as, ds, wa);
        chk("t2_gnt_wait", gw, 0);
        chk("t2_flags", fl, 4'b1100);
        chk("t2_addr", as, 12'h123);
        chk("t2_din", ds, 60'hABC);
        chk("t2_we_pulse", wa, 0);
        do_write(12'h124, 60'hDEF, gw, fl, as, ds, wa);
        chk("t2_b2b_gnt_wait", gw, 0);
        chk("t2_b2b_din", ds, 60'hDEF);
        do_read(12'h123, d, gw, lat, er, mask, as);
        chk("t2_rd_data", d, 60'hABC);
        do_read(12'h124, d, gw, lat, er, mask, as);
        chk("t2_rd_data2", d, 60'hDEF);
        last_d = 60'hDEF;

        // 3: both requests held -> R,R,R,R,W repeating
        begin
            int g, n;
            g = 0; n = 0;
            rd_req_i = 1'b1; rd_addr_i = 12'h201;
            wr_req_i = 1'b1; wr_addr_i = 12'h200; wr_data_i = 60'h1234;
            while (g < 15 && n < 300) begin
                #1;
                if (rd_gnt_o || wr_gnt_o) begin
                    chk($sformatf("t3_gnt_%0d", g), {rd_gnt_o, wr_gnt_o}, (g % 5 == 4) ? 2'b01 : 2'b10);
                    g++;
                end
                @(posedge clk_i); #1;
                n++;
            end
            rd_req_i = 1'b0; wr_req_i = 1'b0;
            chk("t3_grant_count", g, 15);
            exp_mem[12'h200] = 60'h1234;
            exp_seen[12'h200] = 1'b1;
            repeat (6) tick();
            last_d = pattern(12'h201);
            chk("t3_last_rd", rd_data_o, last_d);
        end

        // 4: response suppressed -> timeout, then normal read
        no_rsp = 1'b1;
        do_read(12'h020, d, gw, lat, er, mask, as);
        chk("t4_err_pulse", er, 1);
        chk("t4_latency", lat, 9);
        chk("t4_data_unchanged", d, last_d);
        chk("t4_err_sticky", err_o, 1);
        no_rsp = 1'b0;
        tick();
        chk("t4_rd_err_clear", rd_err_o, 0);
        chk("t4_err_still", err_o, 1);
        do_read(12'h030, d, gw, lat, er, mask, as);
        chk("t4_next_data", d, pattern(12'h030));
        chk("t4_next_lat", lat, 4);
        chk("t4_err_kept", err_o, 1);

        // 5: reset during RD_WAIT
        rd_req_i = 1'b1; rd_addr_i = 12'h040;
        #1 chk("t5_gnt", rd_gnt_o, 1);
        tick();
        rd_req_i = 1'b0;
        tick();
        rstn_i = 1'b0;
        #1;
        chk("t5_rd_data", rd_data_o, 0);
        chk("t5_err", err_o, 0);
        chk("t5_fb_en", fb_en_o, 0);
        chk("t5_fb_addr", fb_addr_o, 0);
        chk("t5_misc", {rd_valid_o, rd_err_o, fb_we_o, fb_rd_req_o, rd_gnt_o, wr_gnt_o}, 0);
        repeat (2) @(posedge clk_i);
        #1 rstn_i = 1'b1;
        begin
            int nv;
            nv = 0;
            repeat (8) begin
                tick();
                if (rd_valid_o || fb_en_o || rd_err_o) nv++;
            end
            chk("t5_quiet_after", nv, 0);
        end
        do_read(12'h050, d, gw, lat, er, mask, as);
        chk("t5_idle_gnt", gw, 0);
        chk("t5_read_ok", d, pattern(12'h050));

        // 6: random mix against scoreboard
        for (int i = 0; i < 40; i++) begin
            logic [11:0] a;
            logic [59:0] v;
            a = 12'h300 + 12'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                v = {28'($urandom), 32'($urandom)};
                do_write(a, v, gw, fl, as, ds, wa);
                chk($sformatf("t6_wr_din_%0d", i), ds, v);
            end else begin
                do_read(a, d, gw, lat, er, mask, as);
                chk($sformatf("t6_rd_%0d", i), d, exp_rd(a));
            end
        end
        repeat (4) tick();
        chk("we_rdreq_exclusive", excl_viol, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
